execute_pipe: RTL and testbench

EXECUTE_PIPE -- requirements
Module: execute_pipe

---
 rtl/execute_pipe.sv | 165 ++++++++++++++++
 tb/tb_execute_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_pipe.sv
// Execute stage: one-slot output register holding ALU result, zero flag, branch target and store data.
// Define EXECUTE_PIPE_MUL_EN to add the iterative shift-add multiplier behind opcode 1000.
module execute_pipe #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_E,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M,
  output logic         zero_M,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         mul_busy
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic [N-1:0] w_src_b;
  logic [N-1:0] w_alu;
  logic [N-1:0] w_pcb;
  logic [N-1:0] w_res;
  logic         w_slot_free;
  logic         w_accept;
  logic         w_idle;
  logic         w_wr_res;

  function automatic logic [N-1:0] alu_op(input logic [3:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_PASS: r = b;
      OP_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign w_src_b     = AluSrc ? signImm_E : readData2_E;
  assign w_alu       = alu_op(AluControl, readData1_E, w_src_b);
  assign w_pcb       = PC_E + (signImm_E << 2);
  assign w_slot_free = !out_valid || out_ready;
  assign in_ready    = w_idle && w_slot_free && !flush_E;
  assign w_accept    = in_valid && in_ready;

`ifdef EXECUTE_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CW     = $clog2(N);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic         r_done;
  logic [N-1:0] r_acc;
  logic [N-1:0] r_mcand;
  logic [N-1:0] r_mplier;
  logic         w_mul_start;
  logic         w_mul_wr;
  logic         w_mul_step;

  assign w_mul_start = w_accept && (AluControl == OP_MUL);
  assign w_mul_wr    = (r_state == S_MUL) && r_done && w_slot_free && !flush_E;
  assign w_mul_step  = (r_state == S_MUL) && !r_done;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_mul_start) w_state_nxt = S_MUL;
      S_MUL:  if (flush_E || w_mul_wr) w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_idle   = 1'b0;
    mul_busy = 1'b0;
    case (r_state)
      S_IDLE: w_idle   = 1'b1;
      S_MUL:  mul_busy = 1'b1;
    endcase
  end

  // Iteration control: counter parks at N-1 and r_done marks the product complete.
  always_ff @(posedge clk) begin
    if (reset || flush_E || w_mul_start || w_mul_wr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (w_mul_step) begin
      r_cnt  <= (r_cnt == CW'(N - 1)) ? r_cnt : r_cnt + 1'b1;
      r_done <= (r_cnt == CW'(N - 1));
    end
  end

  // Shift-add datapath: one multiplier bit consumed per cycle, product truncated to N bits.
  always_ff @(posedge clk) begin
    if (w_mul_start) begin
      r_acc    <= '0;
      r_mcand  <= readData1_E;
      r_mplier <= w_src_b;
    end else if (w_mul_step) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign w_wr_res = (w_accept && !w_mul_start) || w_mul_wr;
  assign w_res    = w_mul_wr ? r_acc : w_alu;
`else
  assign w_idle   = 1'b1;
  assign mul_busy = 1'b0;
  assign w_wr_res = w_accept;
  assign w_res    = w_alu;
`endif

  // Output slot: branch target and store data are captured at acceptance, the result when it is ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      PCBranch_M  <= '0;
      aluResult_M <= '0;
      writeData_M <= '0;
      zero_M      <= 1'b1;
    end else if (flush_E) begin
      out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        PCBranch_M  <= w_pcb;
        writeData_M <= readData2_E;
      end
      if (w_wr_res) begin
        aluResult_M <= w_res;
        zero_M      <= (w_res == '0);
        out_valid   <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_pipe.sv
// Self-checking bench for execute_pipe: directed scenarios plus a randomized run against a behavioural model.
module tb_execute_pipe;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset, flush_E, in_valid, in_ready, AluSrc;
  logic [3:0]   AluControl;
  logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E;
  logic [N-1:0] PCBranch_M, aluResult_M, writeData_M;
  logic         zero_M, out_valid, out_ready, mul_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_pipe #(.N(N)) dut (
    .clk(clk), .reset(reset), .flush_E(flush_E), .in_valid(in_valid), .in_ready(in_ready),
    .AluSrc(AluSrc), .AluControl(AluControl), .PC_E(PC_E), .signImm_E(signImm_E),
    .readData1_E(readData1_E), .readData2_E(readData2_E), .PCBranch_M(PCBranch_M),
    .aluResult_M(aluResult_M), .writeData_M(writeData_M), .zero_M(zero_M),
    .out_valid(out_valid), .out_ready(out_ready), .mul_busy(mul_busy)
  );

  function automatic logic [N-1:0] ref_alu(input logic [3:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      4'b1100: return ~(a | b);
`ifdef EXECUTE_PIPE_MUL_EN
      4'b1000: return a * b;
`endif
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] rd2,
                       input logic [N-1:0] imm, input logic src, input logic [N-1:0] pc);
    in_valid = 1'b1; AluControl = op; readData1_E = a; readData2_E = rd2;
    signImm_E = imm; AluSrc = src; PC_E = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush_E = 1'b0; out_ready = 1'b1;
    drive(4'b0010, 64'd9, 64'd1, 64'd4, 1'b0, 64'h40);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (aluResult_M !== '0) begin errors++; $display("FAIL reset_alu got %h want 0", aluResult_M); end
    checks++; if (PCBranch_M !== '0) begin errors++; $display("FAIL reset_pcb got %h want 0", PCBranch_M); end
    checks++; if (writeData_M !== '0) begin errors++; $display("FAIL reset_wd got %h want 0", writeData_M); end
    checks++; if (zero_M !== 1'b1) begin errors++; $display("FAIL reset_zero got %0b want 1", zero_M); end
    checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", mul_busy); end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b want 1", in_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(4'b0010, 64'd5, 64'd3, 64'h10, 1'b0, 64'h40);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_rdy got %0b want 1", in_ready); end
    tick(); in_valid = 1'b0;
    checks++; if (aluResult_M !== 64'd8) begin errors++; $display("FAIL add_res got %h want 8", aluResult_M); end
    checks++; if (zero_M !== 1'b0) begin errors++; $display("FAIL add_zero got %0b want 0", zero_M); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b want 1", out_valid); end
    checks++; if (writeData_M !== 64'd3) begin errors++; $display("FAIL add_wd got %h want 3", writeData_M); end
    checks++; if (PCBranch_M !== 64'h80) begin errors++; $display("FAIL add_pcb got %h want 80", PCBranch_M); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_sub_zero();
    out_ready = 1'b1;
    drive(4'b0110, 64'd7, 64'h55, 64'd7, 1'b1, 64'h100);
    tick(); in_valid = 1'b0;
    checks++; if (aluResult_M !== '0) begin errors++; $display("FAIL sub_res got %h want 0", aluResult_M); end
    checks++; if (zero_M !== 1'b1) begin errors++; $display("FAIL sub_zero got %0b want 1", zero_M); end
    checks++; if (PCBranch_M !== 64'h11C) begin errors++; $display("FAIL sub_pcb got %h want 11c", PCBranch_M); end
    checks++; if (writeData_M !== 64'h55) begin errors++; $display("FAIL sub_wd got %h want 55", writeData_M); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(4'b0000, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 64'd0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy0 got %0b want 1", in_ready); end
    tick();
    checks++; if (aluResult_M !== 64'hF000 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_and got %h/%0b want f000/1", aluResult_M, out_valid); end
    drive(4'b0001, 64'h0F, 64'hF0, 64'd0, 1'b0, 64'd0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy1 got %0b want 1", in_ready); end
    tick(); in_valid = 1'b0;
    checks++; if (aluResult_M !== 64'hFF || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_or got %h/%0b want ff/1", aluResult_M, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(4'b1100, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0);
    tick();
    drive(4'b0010, 64'd1, 64'd1, 64'd0, 1'b0, 64'h8);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy got %0b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (aluResult_M !== {N{1'b1}} || out_valid !== 1'b1 || PCBranch_M !== '0) begin
        errors++; $display("FAIL bp_hold got %h/%0b want all-ones/1", aluResult_M, out_valid); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_free got %0b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(4'b0111, 64'd0, 64'h1234, 64'd0, 1'b0, 64'd0);
    tick();
    checks++; if (aluResult_M !== 64'h1234 || out_valid !== 1'b1) begin errors++; $display("FAIL fl_pre got %h/%0b want 1234/1", aluResult_M, out_valid); end
    flush_E = 1'b1; out_ready = 1'b1;
    drive(4'b0010, 64'd2, 64'd2, 64'd0, 1'b0, 64'd0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_rdy got %0b want 0", in_ready); end
    tick(); flush_E = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %0b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_noacc got %0b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic         m_valid = 1'b0, m_zero = 1'b1;
    logic [N-1:0] m_res = '0, m_pcb = '0, m_wd = '0;
    logic         exp_rdy;
    for (int c = 0; c < 400; c++) begin
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid c=%0d got %0b want %0b", c, out_valid, m_valid); end
      checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL rnd_busy c=%0d got %0b want 0", c, mul_busy); end
      if (m_valid) begin
        checks++; if (aluResult_M !== m_res || zero_M !== m_zero || PCBranch_M !== m_pcb || writeData_M !== m_wd) begin
          errors++; $display("FAIL rnd_data c=%0d got %h/%0b/%h/%h want %h/%0b/%h/%h", c,
                             aluResult_M, zero_M, PCBranch_M, writeData_M, m_res, m_zero, m_pcb, m_wd); end
      end
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      AluControl = 4'($urandom_range(0, 15));
`ifdef EXECUTE_PIPE_MUL_EN
      if (AluControl == 4'b1000) AluControl = 4'b0010;
`endif
      readData1_E = {$urandom, $urandom}; readData2_E = {$urandom, $urandom};
      signImm_E = {$urandom, $urandom}; PC_E = {$urandom, $urandom};
      AluSrc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        AluControl = 4'b0110; AluSrc = 1'b0; readData2_E = readData1_E;
      end
      #1;
      exp_rdy = !m_valid || out_ready;
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_rdy c=%0d got %0b want %0b", c, in_ready, exp_rdy); end
      if (in_valid && exp_rdy) begin
        m_res = ref_alu(AluControl, readData1_E, AluSrc ? signImm_E : readData2_E);
        m_zero = (m_res == '0);
        m_pcb = PC_E + signImm_E * 4;
        m_wd = readData2_E;
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

`ifdef EXECUTE_PIPE_MUL_EN
  task automatic test_mul_backpressure();
    int lat = 0;
    out_ready = 1'b0;
    drive(4'b1000, {N{1'b1}}, 64'd3, 64'd4, 1'b0, 64'h200);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_rdy0 got %0b want 1", in_ready); end
    tick(); in_valid = 1'b0;
    while (!out_valid && lat < N + 8) begin
      checks++; if (mul_busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy lat=%0d got %0b/%0b want 1/0", lat, mul_busy, in_ready); end
      tick(); lat++;
    end
    checks++; if (out_valid !== 1'b1 || lat < N || lat > N + 2) begin errors++; $display("FAIL mul_lat got %0d valid %0b want %0d..%0d", lat, out_valid, N, N + 2); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (aluResult_M !== 64'hFFFF_FFFF_FFFF_FFFD || zero_M !== 1'b0 || PCBranch_M !== 64'h210 || writeData_M !== 64'd3) begin
        errors++; $display("FAIL mul_res got %h/%0b/%h/%h want fffffffffffffffd/0/210/3", aluResult_M, zero_M, PCBranch_M, writeData_M); end
      checks++; if (mul_busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mul_hold got %0b/%0b/%0b want 0/0/1", mul_busy, in_ready, out_valid); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_flush_mul();
    out_ready = 1'b1;
    drive(4'b1000, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0, 1'b0, 64'd0);
    tick(); in_valid = 1'b0;
    repeat (10) tick();
    checks++; if (mul_busy !== 1'b1) begin errors++; $display("FAIL fmul_pre got %0b want 1", mul_busy); end
    flush_E = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fmul_rdy got %0b want 0", in_ready); end
    tick(); flush_E = 1'b0;
    checks++; if (mul_busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL fmul_abort got %0b/%0b want 0/0", mul_busy, out_valid); end
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fmul_rdy1 got %0b want 1", in_ready); end
    repeat (N + 4) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmul_ghost got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mul();
    out_ready = 1'b1;
    drive(4'b1000, 64'd12345, 64'd678, 64'd5, 1'b0, 64'h300);
    tick(); in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || mul_busy !== 1'b0 || zero_M !== 1'b1) begin errors++; $display("FAIL rmul_ctl got %0b/%0b/%0b want 0/0/1", out_valid, mul_busy, zero_M); end
    checks++; if (aluResult_M !== '0 || PCBranch_M !== '0 || writeData_M !== '0) begin errors++; $display("FAIL rmul_data got %h/%h/%h want 0", aluResult_M, PCBranch_M, writeData_M); end
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmul_rdy got %0b want 1", in_ready); end
    repeat (N + 4) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmul_ghost got %0b want 0", out_valid); end
  endtask

  task automatic test_mul_random();
    logic [N-1:0] a, b, exp;
    int lat;
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      if (t == 0) b = '0;
      exp = a * b;
      drive(4'b1000, a, 64'd0, b, 1'b1, 64'd0);
      tick(); in_valid = 1'b0; lat = 0;
      while (!out_valid && lat < N + 8) begin tick(); lat++; end
      checks++; if (out_valid !== 1'b1 || aluResult_M !== exp || zero_M !== (exp == '0)) begin
        errors++; $display("FAIL mulr t=%0d got %h/%0b want %h/%0b", t, aluResult_M, zero_M, exp, exp == '0); end
      tick();
    end
  endtask
`else
  task automatic test_mul_off();
    out_ready = 1'b1;
    drive(4'b1000, 64'd4, 64'd2, 64'd0, 1'b0, 64'd0);
    #1;
    checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL off_busy0 got %0b want 0", mul_busy); end
    tick(); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || aluResult_M !== '0 || zero_M !== 1'b1) begin errors++; $display("FAIL off_res got %0b/%h/%0b want 1/0/1", out_valid, aluResult_M, zero_M); end
    checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL off_busy1 got %0b want 0", mul_busy); end
    tick();
    checks++; if (mul_busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL off_after got %0b/%0b want 0/0", mul_busy, out_valid); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush_E = 1'b0; in_valid = 1'b0; out_ready = 1'b0; AluSrc = 1'b0;
    AluControl = '0; PC_E = '0; signImm_E = '0; readData1_E = '0; readData2_E = '0;
    test_reset();
    test_add();
    test_sub_zero();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
`ifdef EXECUTE_PIPE_MUL_EN
    test_mul_backpressure();
    test_flush_mul();
    test_reset_mul();
    test_mul_random();
`else
    test_mul_off();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
